// File: rtl/contador_param.sv
// Parameterised up/down/step/load counter with registered ripple-carry/borrow
// flag and a one-cycle load-complete pulse; wrap-around or saturating arithmetic.
module contador_param #(
  parameter int              WIDTH  = 8,
  parameter longint unsigned STEP   = 3,
  parameter bit              SAT_EN = 1'b0
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             enable,
  input  logic [1:0]       modo,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             rco,
  output logic             load_done
);

  typedef enum logic [1:0] {
    OP_UP   = 2'b00,
    OP_DOWN = 2'b01,
    OP_STEP = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  localparam logic [WIDTH:0]   ONE_X  = (WIDTH+1)'(1);
  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] Q_MAX  = '1;

  op_e            op;
  logic [WIDTH:0] q_ext;
  logic [WIDTH:0] sum_up;
  logic [WIDTH:0] diff_one;
  logic [WIDTH:0] diff_step;

  logic [WIDTH-1:0] q_nxt;
  logic             rco_nxt;
  logic             ld_nxt;

  assign op        = op_e'(modo);
  assign q_ext     = {1'b0, Q};
  // One extra bit on every datapath: its MSB is the exact carry/borrow.
  assign sum_up    = q_ext + ONE_X;
  assign diff_one  = q_ext - ONE_X;
  assign diff_step = q_ext - STEP_X;

  always_comb begin
    q_nxt   = Q;
    rco_nxt = 1'b0;
    ld_nxt  = 1'b0;
    if (enable) begin
      unique case (op)
        OP_UP: begin
          rco_nxt = sum_up[WIDTH];
          q_nxt   = (SAT_EN && sum_up[WIDTH]) ? Q_MAX : sum_up[WIDTH-1:0];
        end
        OP_DOWN: begin
          rco_nxt = diff_one[WIDTH];
          q_nxt   = (SAT_EN && diff_one[WIDTH]) ? '0 : diff_one[WIDTH-1:0];
        end
        OP_STEP: begin
          rco_nxt = diff_step[WIDTH];
          q_nxt   = (SAT_EN && diff_step[WIDTH]) ? '0 : diff_step[WIDTH-1:0];
        end
        OP_LOAD: begin
          q_nxt  = D;
          ld_nxt = 1'b1;
        end
        default: begin
          q_nxt   = Q;
          rco_nxt = 1'b0;
          ld_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      Q         <= '0;
      rco       <= 1'b0;
      load_done <= 1'b0;
    end else begin
      Q         <= q_nxt;
      rco       <= rco_nxt;
      load_done <= ld_nxt;
    end
  end

endmodule

// File: doc/contador_param.md
CONTADOR_PARAM -- requirements
Module: contador_param

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits; SHALL be legal for 2 to 32.
REQ-002 Parameter STEP, default 3: decrement used in modo=10; SHALL be legal for 1 to 2^WIDTH-1.
REQ-003 Parameter SAT_EN, default 0: 0 = wrap-around arithmetic; 1 = saturating arithmetic.
REQ-004 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-005 reset_L  input  1  reset, asynchronous and active-low.
REQ-006 enable  input  1  1 = perform the modo operation this cycle; 0 = hold.
REQ-007 modo  input  2  operation select:
  - 00 = up by 1
  - 01 = down by 1
  - 10 = down by STEP
  - 11 = load D
REQ-008 D  input  WIDTH  load value, used only when modo=11.
REQ-009 Q  output  WIDTH  registered count.
REQ-010 rco  output  1  registered ripple-carry/borrow flag.
REQ-011 load_done  output  1  registered 1-cycle pulse marking a completed load.

Function
REQ-012 All outputs SHALL be registered; the result of an operation sampled at edge N SHALL appear on Q, rco and load_done after edge N.
REQ-013 enable=0: Q SHALL hold, and rco and load_done SHALL be 0 on the next cycle.
REQ-014 Up by 1 (modo=00): nominal result Q+1; a boundary crossing SHALL be flagged when Q=2^WIDTH-1.
REQ-015 Down by 1 (modo=01): nominal result Q-1; a boundary crossing SHALL be flagged when Q=0.
REQ-016 Down by STEP (modo=10): nominal result Q-STEP; a boundary crossing SHALL be flagged when Q<STEP.
REQ-017 Subtraction with STEP SHALL be computed at WIDTH+1 bits so the borrow is exact for any legal STEP.
REQ-018 SAT_EN=0, boundary crossing: Q SHALL take the nominal result modulo 2^WIDTH (e.g. up from all-ones gives 0; 0x01 minus 3 gives 0xFE for WIDTH=8).
REQ-019 SAT_EN=1, boundary crossing: Q SHALL clamp to 2^WIDTH-1 for up operations and to 0 for down operations.
REQ-020 rco SHALL be 1 for exactly the cycle following each enabled operation that crosses a boundary, and 0 otherwise.
REQ-021 With SAT_EN=1 and the counter held at a bound, rco SHALL re-assert on every further enabled operation that attempts to cross that bound.
REQ-022 Load (modo=11, enable=1): Q SHALL become D, load_done SHALL be 1 for one cycle, and rco SHALL be 0.
REQ-023 Loading 0 or all-ones SHALL NOT assert rco.
REQ-024 load_done SHALL be 0 after every cycle that is not an enabled load.
REQ-025 A modo change on any edge SHALL take effect on that same edge, with no pipeline bubble and no dependency on the previous modo.
REQ-026 Back-to-back loads SHALL each produce a load_done pulse; load_done SHALL stay high continuously while loads repeat.
REQ-027 X on D SHALL NOT propagate to Q unless modo=11 and enable=1.

Reset
REQ-028 reset_L=0 SHALL immediately, without waiting for a clk edge, force Q=0, rco=0 and load_done=0, overriding any operation in progress.
REQ-029 While reset_L=0, all inputs SHALL be ignored.
REQ-030 On the first rising clk edge after reset_L deasserts, the counter SHALL act on the sampled enable and modo normally.
REQ-031 Asserting reset_L mid-count (e.g. Q=0x5A) SHALL clear Q to 0 asynchronously; no rco pulse SHALL be produced by the reset.

Verification (WIDTH=8, STEP=3 unless noted)
REQ-032 Pulse reset_L low between clock edges with Q=0x5A -> Q=0x00, rco=0 and load_done=0 immediately, before the next edge.
REQ-033 Load 0xFE, then two cycles of modo=00 -> sequence:
  - after the load: Q=0xFE, load_done=1
  - next cycle: Q=0xFF, rco=0
  - next cycle: Q=0x00, rco=1
REQ-034 Load 0x01, then modo=10 -> Q=0xFE and rco=1; a further modo=10 -> Q=0xFB and rco=0.
REQ-035 Load 0x10, then enable=0 for 5 cycles with modo cycling through 00/01/10 -> Q stays 0x10, rco=0 and load_done=0 throughout.
REQ-036 SAT_EN=1: load 0x02, then three cycles of modo=10 -> sequence:
  - first cycle: Q=0x00, rco=1
  - second cycle: Q=0x00, rco=1
  - third cycle: Q=0x00, rco=1
  - then modo=00 for one cycle: Q=0x01, rco=0
REQ-037 WIDTH=4, STEP=15, SAT_EN=0: load 0xE, then modo=10 -> Q=0xF and rco=1.
